// File: rtl/restoring_divider_if.sv
// Start/ready/done handshake and operand/result bus of restoring_divider.
// BIT_WIDTH defaults to the BIT_WIDTH macro (4 when not predefined).
`ifndef BIT_WIDTH
`define BIT_WIDTH 4
`endif

interface restoring_divider_if #(
    parameter int BIT_WIDTH = `BIT_WIDTH
);
    logic                 start;
    logic [BIT_WIDTH-1:0] dividend;
    logic [BIT_WIDTH-1:0] divisor;
    logic                 ready;
    logic                 done;
    logic [BIT_WIDTH-1:0] quotient;
    logic [BIT_WIDTH-1:0] remainder;
    logic                 div_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN for the single-cycle divide-by-zero fast path.
`ifndef BIT_WIDTH
`define BIT_WIDTH 4
`endif

module restoring_divider #(
    parameter int BIT_WIDTH = `BIT_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    restoring_divider_if.slave bus
);
    localparam int CW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [BIT_WIDTH-1:0] a_q, d_q, p_q;
    logic [BIT_WIDTH-1:0] a_nxt, p_nxt;
    logic [BIT_WIDTH-1:0] quot_q, rem_q;
    logic [BIT_WIDTH:0]   shifted, trial;
    logic [CW-1:0]        cnt_q;
    logic                 qbit, zero_div;
    logic                 ready_q, done_q, dz_q;

`ifdef DIV_ZERO_DETECT_EN
    assign zero_div = (bus.divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    // P always ends a step below the divisor, so BIT_WIDTH bits hold it
    always_comb begin
        shifted = {p_q, a_q[BIT_WIDTH-1]};
        trial   = shifted - {1'b0, d_q};
        qbit    = ~trial[BIT_WIDTH];
        p_nxt   = qbit ? trial[BIT_WIDTH-1:0] : shifted[BIT_WIDTH-1:0];
        a_nxt   = (a_q << 1) | BIT_WIDTH'(qbit);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = zero_div ? DONE : RUN;
            RUN:     if (cnt_q == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
            done_q  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            d_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    a_q   <= bus.dividend;
                    d_q   <= bus.divisor;
                    p_q   <= '0;
                    cnt_q <= CW'(BIT_WIDTH - 1);
                    if (zero_div) begin
                        quot_q <= '1;
                        rem_q  <= bus.dividend;
                        dz_q   <= 1'b1;
                    end
                end
                RUN: begin
                    p_q   <= p_nxt;
                    a_q   <= a_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        quot_q <= a_nxt;
                        rem_q  <= p_nxt;
                        dz_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
endmodule
